// File: rtl/matmul_pkg.sv
// ----------------------------------------------------------------------------
// matmul_pkg
//  Shared types and constants for the 3x3 8-bit matrix-multiply sequencer.
//  Contents:
//    state_e    sequencer states LOAD_A .. UNLOAD
//    NumElem    elements per matrix (3x3, row-major)
//    DataW      operand element width
//    ResW       result element width
//    IdxW       element index width
//    opnd_elem  extract element k from a packed 72-bit operand bus
//    res_elem   extract element k from a packed 144-bit product bus
// ----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StCompute,
        StCapture,
        StUnload
    } state_e;

    localparam int unsigned NumElem = 9;
    localparam int unsigned DataW   = 8;
    localparam int unsigned ResW    = 16;
    localparam int unsigned IdxW    = $clog2(NumElem);
    localparam int unsigned OpndW   = NumElem * DataW;
    localparam int unsigned ProdW   = NumElem * ResW;

    // Element k lives at [DataW*k + DataW-1 : DataW*k].
    function automatic logic [DataW-1:0] opnd_elem(input logic [OpndW-1:0] bus,
                                                   input int unsigned      k);
        return bus[k*DataW +: DataW];
    endfunction

    // Element k lives at [ResW*k + ResW-1 : ResW*k].
    function automatic logic [ResW-1:0] res_elem(input logic [ProdW-1:0] bus,
                                                 input int unsigned      k);
        return bus[k*ResW +: ResW];
    endfunction

endpackage

// File: rtl/matmul_timeout_ctr.sv
// ----------------------------------------------------------------------------
// matmul_timeout_ctr
//  Idle-gap counter for the operand load phase. Only instantiated when the
//  MATMUL_TIMEOUT_EN macro is defined.
//  Ports:
//    clk       in   clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    clr_i     in   synchronous clear (beat seen or counter not armed)
//    en_i      in   count one idle cycle
//    expire_o  out  high in the idle cycle where the count reaches TimeoutCyc-1
// ----------------------------------------------------------------------------
module matmul_timeout_ctr #(
    parameter int unsigned TimeoutCyc = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned     CntW   = $clog2(TimeoutCyc);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCyc - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// matmul_seq_ctrl
//  Sequencer for the 3x3 8-bit matrix multiplier. Collects A then B as a
//  row-major byte stream, drives the multiplier operand buses, pulses its
//  enable once, captures the 144-bit product and streams nine 16-bit results.
//  Optional feature: define MATMUL_TIMEOUT_EN to abort a stalled load after
//  TIMEOUT_CYC idle cycles (timeout_err pulses); otherwise loads wait forever.
//  Ports:
//    clk, rst_n              clock / asynchronous active-low reset
//    in_data/valid/ready     operand byte stream, A[0][0]..A[2][2] then B
//    out_data/valid/ready    result stream R[0][0]..R[2][2]
//    out_last                marks R[2][2]
//    busy                    first A beat accepted until last result accepted
//    mul_en                  one-cycle multiplier enable
//    mul_a, mul_b            packed operands, element k at [8k+7:8k]
//    mul_result              packed product, element k at [16k+15:16k]
//    timeout_err             one-cycle pulse on load abort
// ----------------------------------------------------------------------------
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W      = DataW,
    parameter int unsigned RES_W       = ResW,
    parameter int unsigned NUM_ELEM    = NumElem,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [RES_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         mul_en,
    output logic [NUM_ELEM*DATA_W-1:0]   mul_a,
    output logic [NUM_ELEM*DATA_W-1:0]   mul_b,
    input  logic [NUM_ELEM*RES_W-1:0]    mul_result,
    output logic                         timeout_err
);

    localparam int unsigned     IW      = $clog2(NUM_ELEM);
    localparam logic [IW-1:0]   LastIdx = IW'(NUM_ELEM - 1);

    state_e                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [NUM_ELEM*DATA_W-1:0]    a_q, a_d;
    logic [NUM_ELEM*DATA_W-1:0]    b_q, b_d;
    logic [NUM_ELEM*RES_W-1:0]     res_q, res_d;

    logic in_beat;
    logic out_beat;
    logic tmo_expire;

    assign in_beat  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;

`ifdef MATMUL_TIMEOUT_EN
    logic tmo_armed;
    logic tmo_clr;
    logic tmo_en;
    logic timeout_err_q, timeout_err_d;

    // Armed only once a load has started: LOAD_A past the first beat, or LOAD_B.
    assign tmo_armed = ((state_q == StLoadA) && (idx_q != '0)) || (state_q == StLoadB);
    assign tmo_clr   = !tmo_armed || in_beat;
    assign tmo_en    = tmo_armed && !in_beat;

    matmul_timeout_ctr #(
        .TimeoutCyc (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    assign timeout_err_d = tmo_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign tmo_expire         = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoadA;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;

        unique case (state_q)
            StLoadA: begin
                if (in_beat) begin
                    a_d[idx_q*DATA_W +: DATA_W] = in_data;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadB: begin
                if (in_beat) begin
                    b_d[idx_q*DATA_W +: DATA_W] = in_data;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StCompute;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                state_d = StCapture;
            end
            StCapture: begin
                // The multiplier registered its product on the mul_en edge.
                res_d   = mul_result;
                state_d = StUnload;
            end
            StUnload: begin
                if (out_beat) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StLoadA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StLoadA;
                idx_d   = '0;
            end
        endcase

        // Expiry only fires in a cycle without a beat, so it never races a write.
        if (tmo_expire) begin
            state_d = StLoadA;
            idx_d   = '0;
        end
    end

    // Outputs.
    always_comb begin
        in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
        mul_en    = (state_q == StCompute);
        out_valid = (state_q == StUnload);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == StUnload) begin
            out_data = res_q[idx_q*RES_W +: RES_W];
            out_last = (idx_q == LastIdx);
        end
        // Idle exactly when waiting for the first A element.
        busy = !((state_q == StLoadA) && (idx_q == '0));
    end

    assign mul_a = a_q;
    assign mul_b = b_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         mul_en;
    logic [71:0]  mul_a;
    logic [71:0]  mul_b;
    logic [143:0] mul_result = '0;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;
    int mul_en_total = 0;

    int unsigned ma [9];
    int unsigned mb [9];
    logic [15:0] exp_r [9];

    always #5 clk = ~clk;

    matmul_seq_ctrl #(
        .DATA_W      (8),
        .RES_W       (16),
        .NUM_ELEM    (9),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .timeout_err (timeout_err)
    );

    // Behavioural multiplier: registers the product on the mul_en edge.
    function automatic logic [143:0] mul_model(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] p;
        int unsigned  s;
        p = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                s = 0;
                for (int unsigned k = 0; k < 3; k++) begin
                    s += {24'd0, opnd_elem(a, i*3+k)} * {24'd0, opnd_elem(b, k*3+j)};
                end
                p[(i*3+j)*16 +: 16] = s[15:0];
            end
        end
        return p;
    endfunction

    always @(posedge clk) begin
        if (mul_en === 1'b1) begin
            mul_en_total <= mul_en_total + 1;
            mul_result   <= mul_model(mul_a, mul_b);
        end
    end

    // Reference: R = A x B with integer arithmetic, reduced modulo 2^16.
    function automatic void compute_ref();
        int unsigned s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += ma[i*3+k] * mb[k*3+j];
                exp_r[i*3+j] = 16'(s % 65536);
            end
        end
    endfunction

    function automatic void rand_mats();
        for (int e = 0; e < 9; e++) begin
            ma[e] = $urandom_range(255, 0);
            mb[e] = $urandom_range(255, 0);
        end
    endfunction

    // Beats e in [first, last) of the 18-element A-then-B stream.
    task automatic load_mats(input int gap_max, input int first, input int last);
        for (int e = first; e < last; e++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready beat %0d: in_ready=%b want 1", e, in_ready);
            end
            checks++;
            if (busy !== (e != 0)) begin
                errors++;
                $display("FAIL load_busy beat %0d: busy=%b want %b", e, busy, e != 0);
            end
            in_valid = 1'b1;
            in_data  = (e < 9) ? 8'(ma[e]) : 8'(mb[e-9]);
            @(posedge clk);
        end
    endtask

    task automatic check_latency(input bit hold);
        @(negedge clk);
        in_valid = hold;
        in_data  = 8'($urandom);
        checks++;
        if (mul_en !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL compute_cycle: mul_en=%b in_ready=%b out_valid=%b want 1 0 0",
                     mul_en, in_ready, out_valid);
        end
        @(negedge clk);
        in_data = 8'($urandom);
        checks++;
        if (mul_en !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL capture_cycle: mul_en=%b in_ready=%b out_valid=%b want 0 0 0",
                     mul_en, in_ready, out_valid);
        end
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
    task automatic collect(input int mode, input bit hold, input int stop_after);
        int          n;
        int          cyc;
        bit          prev_stall;
        logic [15:0] pd;
        logic        pl;
        n = 0;
        cyc = 0;
        prev_stall = 1'b0;
        pd = '0;
        pl = 1'b0;
        while (n < stop_after && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 3 == 0);
            else                out_ready = 1'($urandom_range(1, 0));
            if (cyc == 1) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid_latency: out_valid=%b want 1", out_valid);
                end
            end
            if (hold) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_in_ready: in_ready=%b want 0", in_ready);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b data=%0d last=%b want 1 %0d %b",
                             out_valid, out_data, out_last, pd, pl);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (out_data !== exp_r[n]) begin
                    errors++;
                    $display("FAIL out_data[%0d]: got %0d want %0d", n, out_data, exp_r[n]);
                end
                checks++;
                if (out_last !== (n == 8)) begin
                    errors++;
                    $display("FAIL out_last[%0d]: got %b want %b", n, out_last, n == 8);
                end
                n++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            pd = out_data;
            pl = out_last;
        end
        checks++;
        if (n != stop_after) begin
            errors++;
            $display("FAIL collect_budget: got %0d results want %0d", n, stop_after);
        end
    endtask

    task automatic check_done();
        logic [71:0] ea;
        logic [71:0] eb;
        for (int e = 0; e < 9; e++) begin
            ea[e*8 +: 8] = 8'(ma[e]);
            eb[e*8 +: 8] = 8'(mb[e]);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL done_state: valid=%b busy=%b in_ready=%b last=%b want 0 0 1 0",
                     out_valid, busy, in_ready, out_last);
        end
        checks++;
        if (mul_a !== ea || mul_b !== eb) begin
            errors++;
            $display("FAIL operands_retained: a=%h b=%h want %h %h", mul_a, mul_b, ea, eb);
        end
    endtask

    task automatic run_op(input int gap_max, input int mode, input bit hold);
        int m0;
        m0 = mul_en_total;
        compute_ref();
        load_mats(gap_max, 0, 18);
        check_latency(hold);
        collect(mode, hold, 9);
        check_done();
        checks++;
        if (mul_en_total - m0 != 1) begin
            errors++;
            $display("FAIL mul_en_count: got %0d want 1", mul_en_total - m0);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 16'd0
            || busy !== 1'b0 || mul_en !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b data=%0d busy=%b en=%b te=%b",
                     in_ready, out_valid, out_last, out_data, busy, mul_en, timeout_err);
        end
        checks++;
        if (mul_a !== 72'd0 || mul_b !== 72'd0) begin
            errors++;
            $display("FAIL reset_operands: a=%h b=%h want 0 0", mul_a, mul_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        for (int e = 0; e < 9; e++) begin
            ma[e] = (e % 4 == 0) ? 1 : 0;
            mb[e] = e + 1;
        end
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        for (int e = 0; e < 9; e++) begin
            ma[e] = 255;
            mb[e] = 255;
        end
        run_op(1, 0, 1'b0);
    endtask

    task automatic test_stall();
        rand_mats();
        run_op(1, 1, 1'b0);
    endtask

    task automatic test_hold_valid();
        rand_mats();
        run_op(0, 0, 1'b1);
        rand_mats();
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_unload();
        rand_mats();
        compute_ref();
        load_mats(0, 0, 18);
        check_latency(1'b0);
        collect(0, 1'b0, 4);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_r[4]) begin
            errors++;
            $display("FAIL pre_reset_elem4: valid=%b data=%0d want 1 %0d",
                     out_valid, out_data, exp_r[4]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'd0
            || mul_a !== 72'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b rdy=%b data=%0d a=%h want 0 0 1 0 0",
                     out_valid, busy, in_ready, out_data, mul_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rand_mats();
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            rand_mats();
            run_op(2, 2, 1'b0);
        end
    endtask

    // Load resumes after an idle gap of 'idle' cycles that must not trip an abort.
    task automatic test_long_gap(input int idle);
        bit any_err;
        rand_mats();
        compute_ref();
        load_mats(0, 0, 3);
        any_err = 1'b0;
        repeat (idle) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (timeout_err !== 1'b0) any_err = 1'b1;
        end
        checks++;
        if (any_err || busy !== 1'b1) begin
            errors++;
            $display("FAIL long_gap_no_abort: timeout_err_seen=%b busy=%b want 0 1",
                     any_err, busy);
        end
        load_mats(0, 3, 18);
        check_latency(1'b0);
        collect(0, 1'b0, 9);
        check_done();
    endtask

`ifdef MATMUL_TIMEOUT_EN
    task automatic test_timeout();
        int seen;
        rand_mats();
        load_mats(0, 0, 3);
        seen = 0;
        for (int n = 1; n <= 1100 && seen == 0; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (timeout_err === 1'b1) seen = n;
        end
        checks++;
        if (seen != 1025) begin
            errors++;
            $display("FAIL timeout_cycle: pulse at idle cycle %0d want 1025", seen);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: busy=%b in_ready=%b want 0 1", busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: timeout_err=%b want 0", timeout_err);
        end
        rand_mats();
        run_op(0, 0, 1'b0);
        // Beat lands in the expiry cycle: accepted, no abort.
        test_long_gap(1023);
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_wrap();
        test_stall();
        test_hold_valid();
        test_reset_mid_unload();
        test_random();
`ifdef MATMUL_TIMEOUT_EN
        test_timeout();
`else
        test_long_gap(1100);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
